// File: rtl/ab_feeder_pkg.sv
// Shared definitions for the A/B operand feeder and its downstream consumer.
package ab_feeder_pkg;
  localparam int NPAIR_DEF = 8;
  localparam int DW_DEF    = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic int idx_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/ab_feeder_ab_table.sv
// NPAIR-entry {A,B} register file: one write port, one registered read port.
import ab_feeder_pkg::*;

module ab_table #(
  parameter int NPAIR = NPAIR_DEF,
  parameter int DW    = DW_DEF,
  parameter int AW    = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          WE,
  input  logic [AW-1:0] WADDR,
  input  logic [DW-1:0] WDATA_A,
  input  logic [DW-1:0] WDATA_B,
  input  logic          RE,
  input  logic [AW-1:0] RADDR,
  output logic [DW-1:0] RDATA_A,
  output logic [DW-1:0] RDATA_B
);
  logic [NPAIR-1:0][DW-1:0] mem_a;
  logic [NPAIR-1:0][DW-1:0] mem_b;

  // Read and write share one edge, so a colliding read sees the pre-write entry.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mem_a   <= '0;
      mem_b   <= '0;
      RDATA_A <= '0;
      RDATA_B <= '0;
    end else begin
      if (WE) begin
        mem_a[WADDR] <= WDATA_A;
        mem_b[WADDR] <= WDATA_B;
      end
      if (RE) begin
        RDATA_A <= mem_a[RADDR];
        RDATA_B <= mem_b[RADDR];
      end
    end
  end
endmodule

// File: rtl/ab_feeder.sv
// Streams NPAIR stored (A,B) pairs to a consumer per request, with stall and abort.
import ab_feeder_pkg::*;

module ab_feeder #(
  parameter int NPAIR = NPAIR_DEF,
  parameter int DW    = DW_DEF,
  localparam int AW   = (NPAIR > 1) ? $clog2(NPAIR) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          WE,
  input  logic [AW-1:0] WADDR,
  input  logic [DW-1:0] WDATA_A,
  input  logic [DW-1:0] WDATA_B,
  input  logic          REQ_AB,
  input  logic          PAUSE,
  input  logic          HALT,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic          ACK,
  output logic          BUSY,
  output logic          DONE
);
  localparam int IW = idx_w(NPAIR);

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          issue;

  assign issue = (state == S_SEND) && REQ_AB && !PAUSE && !HALT && !RST &&
                 (idx < IW'(NPAIR));

  ab_table #(.NPAIR(NPAIR), .DW(DW), .AW(AW)) u_table (
    .CLK     (CLK),
    .RST     (RST),
    .WE      (WE),
    .WADDR   (WADDR),
    .WDATA_A (WDATA_A),
    .WDATA_B (WDATA_B),
    .RE      (issue),
    .RADDR   (idx[AW-1:0]),
    .RDATA_A (A),
    .RDATA_B (B)
  );

  always_ff @(posedge CLK) begin
    if (RST || HALT) begin
      state <= S_IDLE;
      idx   <= '0;
      ACK   <= 1'b0;
      DONE  <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      ACK  <= 1'b0;
      DONE <= 1'b0;
      case (state)
        S_IDLE: if (REQ_AB) begin
          state <= S_SEND;
          idx   <= '0;
          BUSY  <= 1'b1;
        end
        S_SEND: begin
          if (issue) begin
            ACK <= 1'b1;
            idx <= idx + IW'(1);
          end else if (idx == IW'(NPAIR)) begin
            // Last pair already on the bus; DONE follows it directly.
            state <= S_DONE;
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ab_feeder.sv
// Directed bench for ab_feeder: burst, stall, abort, write collision and reset.
module tb_ab_feeder;
  localparam int NPAIR = 8;
  localparam int DW    = 8;

  logic          CLK = 1'b0;
  logic          RST, WE, REQ_AB, PAUSE, HALT;
  logic [2:0]    WADDR;
  logic [DW-1:0] WDATA_A, WDATA_B;
  logic [DW-1:0] A, B;
  logic          ACK, BUSY, DONE;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_a [NPAIR];
  logic [DW-1:0] exp_b [NPAIR];

  ab_feeder #(.NPAIR(NPAIR), .DW(DW)) dut (
    .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WDATA_A(WDATA_A),
    .WDATA_B(WDATA_B), .REQ_AB(REQ_AB), .PAUSE(PAUSE), .HALT(HALT),
    .A(A), .B(B), .ACK(ACK), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_default_exp();
    for (int i = 0; i < NPAIR; i++) begin
      exp_a[i] = 8'd1;
      exp_b[i] = DW'(i + 1);
    end
  endtask

  // Full uninterrupted burst checked against exp_a/exp_b.
  task automatic run_burst(input string tag);
    REQ_AB = 1'b1;
    tick();
    n_tests++;
    if (ACK !== 1'b0 || BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_accept ack=%b busy=%b want ack=0 busy=1", tag, ACK, BUSY);
    end
    for (int k = 0; k < NPAIR; k++) begin
      tick();
      n_tests++;
      if (ACK !== 1'b1 || A !== exp_a[k] || B !== exp_b[k] || DONE !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_pair%0d ack=%b a=%h b=%h done=%b want ack=1 a=%h b=%h done=0",
                 tag, k, ACK, A, B, DONE, exp_a[k], exp_b[k]);
      end
    end
    REQ_AB = 1'b0;
    tick();
    n_tests++;
    if (ACK !== 1'b0 || DONE !== 1'b1 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done ack=%b done=%b busy=%b want 0 1 0", tag, ACK, DONE, BUSY);
    end
    tick();
    n_tests++;
    if (ACK !== 1'b0 || DONE !== 1'b0 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_after ack=%b done=%b busy=%b want 0 0 0", tag, ACK, DONE, BUSY);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; WE = 1'b0; REQ_AB = 1'b0; PAUSE = 1'b0; HALT = 1'b0;
    WADDR = '0; WDATA_A = '0; WDATA_B = '0;
    tick(); tick();
    n_tests++;
    if ({A, B, ACK, BUSY, DONE} !== '0) begin
      n_fail++;
      $display("FAIL reset a=%h b=%h ack=%b busy=%b done=%b want all 0", A, B, ACK, BUSY, DONE);
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic load_table();
    for (int i = 0; i < NPAIR; i++) begin
      WE = 1'b1; WADDR = 3'(i); WDATA_A = 8'd1; WDATA_B = DW'(i + 1);
      tick();
    end
    WE = 1'b0;
    tick();
  endtask

  task automatic test_burst();
    set_default_exp();
    run_burst("burst");
  endtask

  task automatic test_pause();
    REQ_AB = 1'b1;
    tick();
    for (int k = 0; k < 7; k++) begin
      tick();
      n_tests++;
      if (ACK !== 1'b1 || B !== DW'(k + 1)) begin
        n_fail++;
        $display("FAIL pause_pre%0d ack=%b b=%h want ack=1 b=%h", k, ACK, B, DW'(k + 1));
      end
    end
    PAUSE = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if (ACK !== 1'b0 || DONE !== 1'b0 || BUSY !== 1'b1) begin
        n_fail++;
        $display("FAIL pause_stall%0d ack=%b done=%b busy=%b want 0 0 1", k, ACK, DONE, BUSY);
      end
    end
    PAUSE = 1'b0;
    tick();
    n_tests++;
    if (ACK !== 1'b1 || B !== 8'd8) begin
      n_fail++;
      $display("FAIL pause_resume ack=%b b=%h want ack=1 b=08", ACK, B);
    end
    REQ_AB = 1'b0;
    tick();
    n_tests++;
    if (ACK !== 1'b0 || DONE !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_done ack=%b done=%b want ack=0 done=1", ACK, DONE);
    end
    tick();
  endtask

  task automatic test_halt();
    REQ_AB = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) tick();
    n_tests++;
    if (ACK !== 1'b1 || B !== 8'd3) begin
      n_fail++;
      $display("FAIL halt_third ack=%b b=%h want ack=1 b=03", ACK, B);
    end
    HALT = 1'b1; REQ_AB = 1'b0;
    tick();
    HALT = 1'b0;
    for (int k = 0; k < 12; k++) begin
      n_tests++;
      if (ACK !== 1'b0 || DONE !== 1'b0 || BUSY !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_quiet%0d ack=%b done=%b busy=%b want 0 0 0", k, ACK, DONE, BUSY);
      end
      tick();
    end
    set_default_exp();
    run_burst("halt_restart");
  endtask

  task automatic test_write_collision();
    logic [DW-1:0] want_b [NPAIR];
    for (int i = 0; i < NPAIR; i++) want_b[i] = DW'(i + 1);
    want_b[5] = 8'h55;
    REQ_AB = 1'b1;
    tick();
    for (int k = 0; k < NPAIR; k++) begin
      WE = 1'b0;
      if (k == 4) begin WE = 1'b1; WADDR = 3'd5; WDATA_A = 8'd1; WDATA_B = 8'h55; end
      if (k == 6) begin WE = 1'b1; WADDR = 3'd6; WDATA_A = 8'd1; WDATA_B = 8'h66; end
      tick();
      n_tests++;
      if (ACK !== 1'b1 || B !== want_b[k]) begin
        n_fail++;
        $display("FAIL write_pair%0d ack=%b b=%h want ack=1 b=%h", k, ACK, B, want_b[k]);
      end
    end
    WE = 1'b0; REQ_AB = 1'b0;
    tick();
    tick();
    // Entry 6 now holds the late write.
    exp_b[5] = 8'h55;
    exp_b[6] = 8'h66;
    run_burst("write_after");
  endtask

  task automatic test_idle_halt();
    HALT = 1'b1; REQ_AB = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_tests++;
      if (ACK !== 1'b0 || BUSY !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_halt%0d ack=%b busy=%b want 0 0", k, ACK, BUSY);
      end
    end
    REQ_AB = 1'b0; HALT = 1'b0;
    tick();
    n_tests++;
    if (BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_halt_release busy=%b want 0", BUSY);
    end
  endtask

  task automatic test_rst_midburst();
    REQ_AB = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) tick();
    RST = 1'b1;
    tick();
    n_tests++;
    if ({A, B, ACK, BUSY, DONE} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid a=%h b=%h ack=%b busy=%b done=%b want all 0", A, B, ACK, BUSY, DONE);
    end
    RST = 1'b0; REQ_AB = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (ACK !== 1'b0 || DONE !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_quiet%0d ack=%b done=%b want 0 0", k, ACK, DONE);
      end
    end
    for (int i = 0; i < NPAIR; i++) begin exp_a[i] = '0; exp_b[i] = '0; end
    run_burst("rst_zero");
  endtask

  initial begin
    test_reset();
    load_table();
    test_burst();
    test_pause();
    test_halt();
    test_write_collision();
    test_idle_halt();
    test_rst_midburst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
